sevenseg_reader: RTL
====================

SEVENSEG_READER -- requirements
Module: sevenseg_reader

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive identical samples required before a pattern pair is accepted (legal range 1..15).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: hex1  input  7  tens-digit segment pattern, bit order gfedcba, active-low.
REQ-005 Port: hex0  input  7  units-digit segment pattern, same encoding as hex1.
REQ-006 Port: out_valid  output  1  decoded result available.
REQ-007 Port: out_ready  input  1  consumer accepts the result; transfer occurs when out_valid and out_ready are both high at a clock edge.
REQ-008 Port: tens  output  4  BCD tens digit, or 4'hF if hex1 is illegal.
REQ-009 Port: units  output  4  BCD units digit, or 4'hF if hex0 is illegal.
REQ-010 Port: value  output  7  binary value tens*10+units (0..99), or 0 when err=1.
REQ-011 Port: err  output  1  at least one of the two patterns is not a legal digit.

Function
REQ-012 Legal patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; every other pattern is illegal.
REQ-013 Sample register in_q captures {hex1,hex0} on every edge.
REQ-014 Stability counter cnt is cleared on an edge where {hex1,hex0} differs from in_q, otherwise increments, saturating at STABLE_CYCLES.
REQ-015 FSM has two states, IDLE and HOLD.
REQ-016 IDLE -> HOLD occurs when cnt==STABLE_CYCLES and either in_q differs from last_q or last_ok=0. On this edge tens, units, value and err load from the decode of in_q, and out_valid rises.
REQ-017 Latency: a new pair first sampled at edge k raises out_valid after edge k+STABLE_CYCLES+1; with the default, this is 5 edges.
REQ-018 HOLD: out_valid=1; tens, units, value and err are held stable until the transfer, regardless of input activity.
REQ-019 HOLD -> IDLE on transfer; on the same edge last_q is set to the emitted pair and last_ok to 1.
REQ-020 The sampling and counting logic keeps running in HOLD. A pair that becomes stable during HOLD is emitted on the first IDLE cycle that meets the REQ-016 condition; the minimum gap is 1 cycle of out_valid=0 after a transfer.
REQ-021 The same pair is never emitted twice in succession. A glitch shorter than STABLE_CYCLES samples produces no emission, and when the input returns to the last emitted pair, nothing is emitted.
REQ-022 Illegal pairs are emitted like legal ones, with err=1, the offending digit field = 4'hF, and value=0.
REQ-023 out_ready is ignored in IDLE.

Reset
REQ-024 While reset_n=0: state=IDLE, out_valid=0, tens=0, units=0, value=0, err=0, in_q=0, cnt=0, last_q=0, last_ok=0, all taking effect immediately without a clock.
REQ-025 Reset asserted during HOLD drops out_valid at once and discards the pending result. The first stable pair after reset release is emitted even if it equals the discarded pair.

Structure
REQ-026 Shared package sevenseg_pkg holds the ten segment constants, the illegal-digit code 4'hF and the IDLE/HOLD state encoding.
REQ-027 One combinational sub-module, seg7_to_bcd (7-bit pattern in; 4-bit digit and illegal flag out), is instantiated twice, once per digit. All sequential logic stays in sevenseg_reader.

Verification
REQ-028 Scenario: reset release, then hex1=1000000 and hex0=0010000 held with out_ready=1 -> out_valid high for exactly 1 cycle, 5 edges after first sample; tens=0, units=9, value=9, err=0.
REQ-029 Scenario: sweep pairs (1,8), (2,7) … (9,0), each held 8 cycles, out_ready=1 -> one emission per pair with value = 18, 27 … 90, in order.
REQ-030 Scenario: out_ready=0 for 10 cycles after valid for pair (4,5); input changes to (6,3) meanwhile -> value=45 held stable until ready rises; then value=63 is emitted after 1 idle cycle.
REQ-031 Scenario: pair (3,3) stable, then a 2-cycle glitch to (7,7), then back to (3,3) -> no emission for the glitch or for the return; exactly one emission total.
REQ-032 Scenario: hex0=1111111 (blank) with hex1 showing 2 -> err=1, tens=2, units=4'hF, value=0.
REQ-033 Scenario: reset_n pulsed low mid-HOLD, then the same pair held -> out_valid falls asynchronously, then the pair is re-emitted after 5 edges.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: segment patterns (gfedcba, active-low), illegal-digit code and FSM states
package sevenseg_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: decodes one active-low 7-segment pattern to a BCD digit.
// Ports: seg (pattern in), digit (BCD or 4'hF), illegal (pattern is not 0..9).
module seg7_to_bcd
  import sevenseg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal
);
  always_comb begin
    illegal = 1'b0;
    case (seg)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: begin
        digit   = DIGIT_ILLEGAL;
        illegal = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/sevenseg_reader.sv
// sevenseg_reader: debounces a two-digit 7-segment display and emits each new stable reading.
// Ports: clk, reset_n (async active-low), hex1/hex0 (segment patterns),
// out_valid/out_ready (handshake), tens/units/value/err (decoded reading).
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] hex1,
  input  logic [6:0] hex0,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic [6:0] value,
  output logic       err
);
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);
  state_t      state_q, state_d;
  logic [13:0] in_q, in_d, last_q, last_d, hold_q, hold_d;
  logic [3:0]  cnt_q, cnt_d, tens_q, tens_d, units_q, units_d;
  logic [6:0]  value_q, value_d;
  logic        err_q, err_d, last_ok_q, last_ok_d;
  logic [3:0]  dig1, dig0;
  logic        bad1, bad0, load, xfer;
  seg7_to_bcd u_dec1 (.seg(in_q[13:7]), .digit(dig1), .illegal(bad1));
  seg7_to_bcd u_dec0 (.seg(in_q[6:0]),  .digit(dig0), .illegal(bad0));
  always_comb begin
    in_d      = {hex1, hex0};
    cnt_d     = (in_d != in_q) ? 4'd0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
    // A stable pair is emitted unless it repeats the last pair actually transferred.
    load      = (state_q == IDLE) && (cnt_q == CNT_MAX) && ((in_q != last_q) || !last_ok_q);
    xfer      = (state_q == HOLD) && out_ready;
    state_d   = load ? HOLD : xfer ? IDLE : state_q;
    hold_d    = load ? in_q : hold_q;
    tens_d    = load ? dig1 : tens_q;
    units_d   = load ? dig0 : units_q;
    err_d     = load ? (bad1 | bad0) : err_q;
    value_d   = !load ? value_q : (bad1 | bad0) ? 7'd0 : 7'(dig1) * 7'd10 + 7'(dig0);
    last_d    = xfer ? hold_q : last_q;
    last_ok_d = xfer | last_ok_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      in_q      <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      last_ok_q <= 1'b0;
      hold_q    <= '0;
      tens_q    <= '0;
      units_q   <= '0;
      value_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_q      <= in_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      last_ok_q <= last_ok_d;
      hold_q    <= hold_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      value_q   <= value_d;
      err_q     <= err_d;
    end
  end
  assign out_valid = (state_q == HOLD);
  assign tens      = tens_q;
  assign units     = units_q;
  assign value     = value_q;
  assign err       = err_q;
endmodule
